// File: rtl/dual_port_ram_pkg.sv
// Shared types and constants for the dual-port RAM with clear sweep.
package dual_port_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

endpackage

// File: rtl/dual_port_ram_param_if.sv
// Port bundle for the dual-port RAM: per-port access signals plus clear/status.
interface dual_port_ram_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  clr;
    logic                  we_A;
    logic                  we_B;
    logic [ADDR_WIDTH-1:0] address_A;
    logic [ADDR_WIDTH-1:0] address_B;
    logic [DATA_WIDTH-1:0] data_in_A;
    logic [DATA_WIDTH-1:0] data_in_B;
    logic [DATA_WIDTH-1:0] data_out_A;
    logic [DATA_WIDTH-1:0] data_out_B;
    logic                  ready;
    logic                  collision;

    modport master (
        output clr, we_A, we_B, address_A, address_B, data_in_A, data_in_B,
        input  data_out_A, data_out_B, ready, collision
    );

    modport slave (
        input  clr, we_A, we_B, address_A, address_B, data_in_A, data_in_B,
        output data_out_A, data_out_B, ready, collision
    );
endinterface

// File: rtl/dpr_clear_seq.sv
// Clear sequencer: sweeps every memory address to zero after reset or a clr request.
//   state | meaning
//   CLEAR | zeroing mem[clr_addr] each edge, ports locked out
//   READY | ports active, waiting for clr
module dpr_clear_seq
    import dual_port_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    clr_state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            busy     <= 1'b1;
            clr_addr <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + ADDR_WIDTH'(1);
                    if (&clr_addr) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: begin
                    if (clr) begin
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        clr_addr <= '0;
                    end
                end
                default: begin
                    state    <= CLEAR;
                    busy     <= 1'b1;
                    clr_addr <= '0;
                end
            endcase
        end
    end

    assign clr_we = busy;

endmodule

// File: rtl/dual_port_ram_param.sv
// True dual-port RAM with registered reads, selectable read/write ordering and a zeroing sweep.
module dual_port_ram_param
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_MODE    = RD_FIRST
) (
    input  logic clk,
    input  logic reset,
    dual_port_ram_param_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  busy;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [DATA_WIDTH-1:0] dout_a;
    logic [DATA_WIDTH-1:0] dout_b;
    logic                  coll;
    logic                  same_addr;
    logic                  port_en;

    dpr_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .clr      (bus.clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign same_addr = (bus.address_A == bus.address_B);
    assign port_en   = !busy && !bus.clr;

    // On a same-address dual write port A wins, so B's write is suppressed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_we) begin
                mem[clr_addr] <= '0;
            end else if (port_en) begin
                if (bus.we_B && !(bus.we_A && same_addr))
                    mem[bus.address_B] <= bus.data_in_B;
                if (bus.we_A)
                    mem[bus.address_A] <= bus.data_in_A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !port_en) begin
            dout_a <= '0;
            dout_b <= '0;
            coll   <= 1'b0;
        end else begin
            coll <= bus.we_A && bus.we_B && same_addr;
            if (RD_MODE == WR_FIRST) begin
                if (bus.we_A)
                    dout_a <= bus.data_in_A;
                else if (bus.we_B && same_addr)
                    dout_a <= bus.data_in_B;
                else
                    dout_a <= mem[bus.address_A];

                if (bus.we_A && same_addr)
                    dout_b <= bus.data_in_A;
                else if (bus.we_B)
                    dout_b <= bus.data_in_B;
                else
                    dout_b <= mem[bus.address_B];
            end else begin
                dout_a <= mem[bus.address_A];
                dout_b <= mem[bus.address_B];
            end
        end
    end

    assign bus.data_out_A = dout_a;
    assign bus.data_out_B = dout_b;
    assign bus.collision  = coll;
    assign bus.ready      = !busy;

endmodule

// File: doc/dual_port_ram_param.md
DUAL_PORT_RAM_PARAM -- requirements
Module: dual_port_ram_param

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DATA_WIDTH  8  word width in bits, >=1.
  ADDR_WIDTH  4  address width; DEPTH = 2**ADDR_WIDTH words.
  RD_MODE     0  0 = read-first (old data), 1 = write-first (new data).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk         input   1           single clock; all logic on its rising edge.
  reset       input   1           synchronous, active-high reset.
  clr         input   1           request to zero all memory words.
  we_A        input   1           port A write enable.
  we_B        input   1           port B write enable.
  address_A   input   ADDR_WIDTH  port A address.
  address_B   input   ADDR_WIDTH  port B address.
  data_in_A   input   DATA_WIDTH  port A write data.
  data_in_B   input   DATA_WIDTH  port B write data.
  data_out_A  output  DATA_WIDTH  port A registered read data.
  data_out_B  output  DATA_WIDTH  port B registered read data.
  ready       output  1           1 = ports accept accesses; 0 = clearing.
  collision   output  1           one-cycle pulse on a same-address dual write.
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 The controller SHALL have two states: CLEAR and READY.
REQ-005 In CLEAR, each edge SHALL write 0 to mem[clr_addr] and increment clr_addr.
REQ-006 The edge that clears address DEPTH-1 SHALL set state to READY and ready to 1, giving exactly DEPTH clearing edges.
REQ-007 In CLEAR, port writes SHALL be ignored, and data_out_A and data_out_B SHALL be 0.
REQ-008 In CLEAR, clr SHALL be ignored; the sweep SHALL not restart.
REQ-009 In READY, clr=1 at an edge SHALL, on that edge:
  - set the state to CLEAR, ready to 0 and clr_addr to 0;
  - ignore port writes;
  - set data_out_A and data_out_B to 0.
REQ-010 In READY, we_x=1 SHALL write data_in_x to mem[address_x] at the edge.
REQ-011 In READY, each port SHALL register read data at every edge, giving 1-cycle read latency.
REQ-012 For an own-port write, data_out_x SHALL be the old word when RD_MODE=0 and data_in_x when RD_MODE=1.
REQ-013 If one port reads an address the other port writes on the same edge, the reader SHALL get the old word when RD_MODE=0 and the new word when RD_MODE=1.
REQ-014 If we_A=we_B=1 and address_A==address_B in READY:
  - port A data SHALL be stored and port B data dropped;
  - collision SHALL be 1 for exactly the next cycle;
  - with RD_MODE=1, both read outputs SHALL return data_in_A.
REQ-015 collision SHALL be 0 in every other cycle.
REQ-016 clr_addr SHALL be ADDR_WIDTH bits and SHALL wrap to 0 after DEPTH-1.

Reset
REQ-017 An edge with reset=1 SHALL set:
  - state to CLEAR and clr_addr to 0;
  - ready, collision, data_out_A and data_out_B to 0.
REQ-018 Reset SHALL take priority over clr and all port activity.
REQ-019 Reset during a sweep SHALL restart the sweep from address 0.
REQ-020 The first edge with reset=0 SHALL clear address 0, so ready rises DEPTH edges after reset deasserts.

Structure
REQ-021 A package dual_port_ram_pkg SHALL hold:
  - the state enumeration (CLEAR, READY);
  - the RD_MODE constants RD_FIRST=0 and WR_FIRST=1.
REQ-022 The clear state machine and clr_addr counter SHALL be one sub-module, dpr_clear_seq, with outputs busy, clr_we and clr_addr.
REQ-023 The memory array and both port datapaths SHALL be in dual_port_ram_param.

Verification
REQ-024 The bench SHALL use DATA_WIDTH=8 and ADDR_WIDTH=4, and SHALL cover these scenarios:
  - Reset, then release: ready=0 for 16 edges, then 1; reading addresses 0..15 on both ports returns 8'h00.
  - RD_MODE=0, mem[3]=8'h11, A writes 8'h55 to 3: data_out_A=8'h11 next cycle, 8'h55 the cycle after; RD_MODE=1 gives 8'h55 immediately.
  - A writes 8'h55 and B writes 8'h66, both to address 2: collision=1 for one cycle, then mem[2] reads 8'h55 on both ports.
  - A writes 8'hAA to 0 while B reads 0 on the same edge: B sees 8'h00 with RD_MODE=0 and 8'hAA with RD_MODE=1.
  - mem[5]=8'h77, clr pulsed in READY: ready=0 for 16 edges; writes during that window are dropped; mem[5] then reads 8'h00.
  - Reset asserted at clr_addr=7 during a sweep: after release, ready rises after a full 16 edges.
